// File: rtl/sss_com_txfifo_if.sv
// Host/transmitter-side signal bundle for the serial transmit FIFO.
// The master side is the environment (host writer plus transmitter busy);
// the slave side is the FIFO/sequencer itself.
interface sss_com_txfifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                clr_ovf;
  logic                tx_busy;
  logic [7:0]          tx_byte;
  logic                tx_send;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;

  modport master (
    output wr_data, wr_en, clr_ovf, tx_busy,
    input  tx_byte, tx_send, full, empty, level, overflow
  );

  modport slave (
    input  wr_data, wr_en, clr_ovf, tx_busy,
    output tx_byte, tx_send, full, empty, level, overflow
  );
endinterface

// File: rtl/sss_com_txfifo.sv
// Transmit byte FIFO and send sequencer in front of the 8N1 serial transmitter.
// Bytes are queued from the host and handed to the transmitter one at a time,
// pacing on its busy flag, with a timeout for a transmitter that never responds.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a queued byte and a non-busy transmitter
// LOAD      | byte popped, tx_send asserted for this single cycle
// WAIT_BUSY | waiting for the transmitter to raise busy (bounded by TIMEOUT)
// WAIT_DONE | frame in progress, waiting for busy to fall
module sss_com_txfifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk5,
  input  logic                 reset,
  sss_com_txfifo_if.slave      bus
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      tx_byte_q, tx_byte_d;
  logic            tx_send_q, tx_send_d;
  logic [7:0]      mem_q [DEPTH];

  logic            full;
  logic            empty;
  logic            accept;
  logic            drop;
  logic            pop;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // Full is the registered value: a write while full is dropped even if a pop
  // frees a slot at the same edge.
  assign accept = bus.wr_en & ~full;
  assign drop   = bus.wr_en & full;

  // Sequencer: next state, pop decision and registered transmitter outputs.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    tx_byte_d = tx_byte_q;
    tx_send_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !bus.tx_busy) begin
          pop       = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          tx_send_d = 1'b1;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // timer counts completed WAIT_BUSY cycles; the state lasts TIMEOUT
        // cycles when busy never rises and the byte is then considered sent.
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping: pointers, occupancy and sticky overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk5 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_byte_q  <= '0;
      tx_send_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_byte_q  <= tx_byte_d;
      tx_send_q  <= tx_send_d;
    end
  end

  // Storage array; contents need no reset since a slot is always written before it is read.
  always_ff @(posedge clk5) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.tx_byte  = tx_byte_q;
  assign bus.tx_send  = tx_send_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = count_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_sss_com_txfifo.sv
// Directed bench for the serial transmit FIFO: a behavioural 8N1 transmitter
// and a line receiver stand in for the real UART; busy can also be forced.
module tb_sss_com_txfifo;

  localparam int BIT = 130;   // 5 MHz / 38400 baud, rounded

  logic clk5  = 1'b0;
  logic reset = 1'b0;
  int   mode  = 2;            // 0 = model transmitter, 1 = dead (busy 0), 2 = busy forced 1

  int checks   = 0;
  int failures = 0;

  sss_com_txfifo_if #(.DEPTH_LOG2(4)) bus ();

  sss_com_txfifo #(.DEPTH_LOG2(4), .TIMEOUT(15)) dut (
    .clk5  (clk5),
    .reset (reset),
    .bus   (bus)
  );

  always #100 clk5 = ~clk5;

  // transmitter model
  logic       m_busy = 1'b0;
  logic       line   = 1'b1;
  logic [9:0] m_sh   = '0;
  int         m_idx  = 0;
  int         m_cnt  = 0;

  assign bus.tx_busy = (mode == 0) ? m_busy : (mode == 2);

  always @(posedge clk5) begin
    if (!m_busy) begin
      if (mode == 0 && bus.tx_send) begin
        m_busy <= 1'b1;
        m_sh   <= {1'b1, bus.tx_byte, 1'b0};
        m_idx  <= 0;
        m_cnt  <= BIT - 1;
        line   <= 1'b0;
      end
    end else if (m_cnt == 0) begin
      if (m_idx == 9) begin
        m_busy <= 1'b0;
        line   <= 1'b1;
      end else begin
        m_idx  <= m_idx + 1;
        line   <= m_sh[m_idx + 1];
        m_cnt  <= BIT - 1;
      end
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  // line receiver, samples mid-bit
  logic       rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_idx = 0;
  logic [7:0] rx_sh  = '0;
  logic [7:0] rx_q[$];
  int         rx_stop_err = 0;

  always @(posedge clk5) begin
    if (rx_act) begin
      if (rx_cnt == 0) begin
        if (rx_idx < 8) begin
          rx_sh[rx_idx] <= line;
          rx_idx <= rx_idx + 1;
          rx_cnt <= BIT - 1;
        end else begin
          rx_act <= 1'b0;
          rx_q.push_back(rx_sh);
          if (line !== 1'b1) rx_stop_err++;
        end
      end else begin
        rx_cnt <= rx_cnt - 1;
      end
    end else if (line == 1'b0) begin
      rx_act <= 1'b1;
      rx_cnt <= BIT + BIT / 2;
      rx_idx <= 0;
    end
  end

  // send monitor
  logic [7:0] sent_q[$];
  int         send_cnt = 0;
  int         busy_viol = 0;

  always @(posedge clk5) begin
    if (bus.tx_send) begin
      sent_q.push_back(bus.tx_byte);
      send_cnt++;
      if (mode == 0 && m_busy) busy_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk5);
    #1;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  task automatic wait_model_idle();
    int k = 0;
    while (m_busy && k < 3000) begin
      cyc();
      k++;
    end
    chk("model_idle", m_busy, 0);
    repeat (4) cyc();
  endtask

  initial begin
    int n;
    int base;

    bus.wr_data = '0;
    bus.wr_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    repeat (3) cyc();

    // reset values
    chk("rst_tx_byte",  bus.tx_byte,  0);
    chk("rst_tx_send",  bus.tx_send,  0);
    chk("rst_full",     bus.full,     0);
    chk("rst_empty",    bus.empty,    1);
    chk("rst_level",    bus.level,    0);
    chk("rst_overflow", bus.overflow, 0);
    reset = 1'b1;
    repeat (2) cyc();

    // 1: single byte through the model transmitter
    mode = 0;
    rx_q.delete();
    bus.wr_data = 8'hA5;
    bus.wr_en   = 1'b1;
    cyc();                                   // edge N
    bus.wr_en   = 1'b0;
    chk("t1_empty_n",   bus.empty,   0);
    chk("t1_level_n",   bus.level,   1);
    chk("t1_send_n",    bus.tx_send, 0);
    cyc();                                   // edge N+1
    chk("t1_send_n1",   bus.tx_send, 1);
    chk("t1_byte_n1",   bus.tx_byte, 8'hA5);
    chk("t1_empty_n1",  bus.empty,   1);
    cyc();                                   // edge N+2
    chk("t1_send_n2",   bus.tx_send, 0);
    wait_rx("t1_rx_cnt", 1, 2000);
    if (rx_q.size() > 0) chk("t1_rx_byte", rx_q[0], 8'hA5);
    chk("t1_stop_bit", rx_stop_err, 0);
    chk("t1_byte_hold", bus.tx_byte, 8'hA5);
    wait_model_idle();

    // 2: burst of 16 while the transmitter is busy, then drain in order
    mode = 2;
    rx_q.delete();
    base = send_cnt;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 8'(i);
      cyc();
    end
    chk("t2_full",  bus.full,  1);
    chk("t2_level", bus.level, 16);
    chk("t2_ovf0",  bus.overflow, 0);
    bus.wr_data = 8'hEE;
    cyc();
    bus.wr_en = 1'b0;
    chk("t2_ovf1",    bus.overflow, 1);
    chk("t2_level17", bus.level,    16);
    bus.clr_ovf = 1'b1;
    cyc();
    bus.clr_ovf = 1'b0;
    chk("t2_ovf_clr", bus.overflow, 0);
    mode = 0;
    wait_rx("t2_rx_cnt", 16, 25000);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk($sformatf("t2_rx%0d", i), rx_q[i], 32'(i));
    chk("t2_sends", send_cnt - base, 16);
    wait_model_idle();

    // 3: dead transmitter, WAIT_BUSY times out after 15 cycles
    mode = 1;
    base = send_cnt;
    bus.wr_data = 8'h3C;
    bus.wr_en   = 1'b1;
    cyc();                                   // edge N
    bus.wr_data = 8'h5A;
    cyc();                                   // edge N+1: first pop
    bus.wr_en   = 1'b0;
    chk("t3_send1", bus.tx_send, 1);
    chk("t3_byte1", bus.tx_byte, 8'h3C);
    n = 0;
    cyc();
    n++;
    while (!bus.tx_send && n < 40) begin
      if (n == 10) chk("t3_byte_hold", bus.tx_byte, 8'h3C);
      cyc();
      n++;
    end
    // LOAD (1) + WAIT_BUSY (15) + IDLE (1)
    chk("t3_gap",   n, 17);
    chk("t3_byte2", bus.tx_byte, 8'h5A);
    repeat (17) cyc();
    chk("t3_empty", bus.empty, 1);
    repeat (20) cyc();
    chk("t3_sends", send_cnt - base, 2);

    // 4: write and pop in the same cycle while full
    mode = 2;
    bus.wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.wr_data = 8'h40 + 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    chk("t4_full", bus.full, 1);
    rx_q.delete();
    bus.wr_data = 8'h99;
    bus.wr_en   = 1'b1;
    mode        = 0;
    cyc();
    chk("t4_ovf",   bus.overflow, 1);
    chk("t4_level", bus.level,    15);
    chk("t4_send",  bus.tx_send,  1);
    chk("t4_byte",  bus.tx_byte,  8'h40);
    bus.wr_data = 8'h50;
    cyc();
    chk("t4_refill", bus.level, 16);
    bus.wr_data = 8'h98;
    bus.clr_ovf = 1'b1;
    cyc();
    bus.wr_en   = 1'b0;
    chk("t4_clr_drop", bus.overflow, 1);
    chk("t4_level16",  bus.level,    16);
    cyc();
    bus.clr_ovf = 1'b0;
    chk("t4_clr", bus.overflow, 0);
    wait_rx("t4_rx_cnt", 17, 26000);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) chk($sformatf("t4_rx%0d", i), rx_q[i], 32'h40 + 32'(i));
    wait_model_idle();

    // 5: reset in WAIT_DONE with 5 bytes queued
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_data = 8'h80 + 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    repeat (3) cyc();
    chk("t5_level_pre", bus.level, 5);
    chk("t5_busy_pre",  bus.tx_busy, 1);
    reset = 1'b0;
    #1;
    chk("t5_send",  bus.tx_send,  0);
    chk("t5_empty", bus.empty,    1);
    chk("t5_level", bus.level,    0);
    chk("t5_ovf",   bus.overflow, 0);
    chk("t5_byte",  bus.tx_byte,  0);
    repeat (2) cyc();
    reset = 1'b1;
    base = send_cnt;
    wait_model_idle();
    repeat (300) cyc();
    chk("t5_no_send", send_cnt - base, 0);

    // 6: order preserved across pointer wrap
    mode = 1;
    sent_q.delete();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wr_data = 8'h60 + 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    repeat (100) cyc();
    bus.wr_en = 1'b1;
    for (int i = 10; i < 20; i++) begin
      bus.wr_data = 8'h60 + 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    chk("t6_ovf", bus.overflow, 0);
    n = 0;
    while (sent_q.size() < 20 && n < 600) begin
      cyc();
      n++;
    end
    chk("t6_cnt", sent_q.size(), 20);
    for (int i = 0; i < 20 && i < sent_q.size(); i++) chk($sformatf("t6_b%0d", i), sent_q[i], 32'h60 + 32'(i));

    chk("busy_viol", busy_viol, 0);
    chk("stop_err",  rx_stop_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
